// File: rtl/lane_load_register_if.sv
// Handshake/bus bundle for lane_load_register: parallel load bus, narrow sequential
// fill stream and register status outputs.
interface lane_load_register_if #(
    parameter int LANE_W = 8,
    parameter int LANES  = 4
);
    localparam int N  = LANE_W * LANES;
    localparam int PW = $clog2(LANES);

    logic              sclr;
    logic              mode;
    logic [LANES-1:0]  ld_en;
    logic [N-1:0]      par_in;
    logic              seq_start;
    logic              seq_valid;
    logic [LANE_W-1:0] seq_data;
    logic              seq_ready;
    logic [N-1:0]      out;
    logic [PW-1:0]     fill_ptr;
    logic              full;
    logic              busy;

    modport master (
        output sclr, mode, ld_en, par_in, seq_start, seq_valid, seq_data,
        input  seq_ready, out, fill_ptr, full, busy
    );

    modport slave (
        input  sclr, mode, ld_en, par_in, seq_start, seq_valid, seq_data,
        output seq_ready, out, fill_ptr, full, busy
    );
endinterface

// File: rtl/lane_load_register.sv
// Multi-lane holding register: per-lane parallel load or low-lane-first sequential fill.
// state | meaning
// IDLE  | no fill in progress; parallel loads allowed when mode=0
// FILL  | accepting one lane per valid beat at fill_ptr
// DONE  | all lanes written since last seq_start; contents held
module lane_load_register #(
    parameter int LANE_W = 8,
    parameter int LANES  = 4
) (
    input  logic                 clk,
    input  logic                 clear_n,
    lane_load_register_if.slave  bus
);
    localparam int N  = LANE_W * LANES;
    localparam int PW = $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_out;
    logic [PW-1:0] r_ptr;
    logic          r_full;
    logic          w_last;

    assign w_last = (r_ptr == PW'(LANES - 1));

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_ptr   <= '0;
            r_full  <= 1'b0;
        end else if (bus.sclr) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_ptr   <= '0;
            r_full  <= 1'b0;
        end else if (!bus.mode) begin
            // Parallel mode aborts any fill; full is intentionally left alone.
            r_state <= S_IDLE;
            r_ptr   <= '0;
            for (int i = 0; i < LANES; i++) begin
                if (bus.ld_en[i]) begin
                    r_out[i*LANE_W +: LANE_W] <= bus.par_in[i*LANE_W +: LANE_W];
                end
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.seq_start) begin
                        r_state <= S_FILL;
                        r_ptr   <= '0;
                        r_full  <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (bus.seq_start) begin
                        r_ptr  <= '0;
                        r_full <= 1'b0;
                    end else if (bus.seq_valid) begin
                        for (int i = 0; i < LANES; i++) begin
                            if (r_ptr == PW'(i)) begin
                                r_out[i*LANE_W +: LANE_W] <= bus.seq_data;
                            end
                        end
                        // Explicit wrap keeps the pointer legal for non-power-of-2 lane counts.
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_full  <= 1'b1;
                            r_ptr   <= '0;
                        end else begin
                            r_ptr <= r_ptr + PW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    assign bus.out       = r_out;
    assign bus.fill_ptr  = r_ptr;
    assign bus.full      = r_full;
    assign bus.seq_ready = (r_state == S_FILL);
    assign bus.busy      = (r_state == S_FILL);
endmodule

// File: tb/tb_lane_load_register.sv
// Scoreboard bench for lane_load_register (LANE_W=8, LANES=4): a reference model pushes
// expected state per driven cycle, popped and compared one cycle later.
module tb_lane_load_register;
    logic clk;
    logic clear_n;
    int   n_checks;
    int   n_fail;

    lane_load_register_if #(.LANE_W(8), .LANES(4)) bus ();

    lane_load_register #(.LANE_W(8), .LANES(4)) u_dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] out;
        logic [1:0]  ptr;
        logic        full;
        logic        rdy;
    } exp_t;

    exp_t q_exp[$];

    logic [31:0] m_out;
    logic [1:0]  m_ptr;
    logic        m_full;
    int          m_st;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out  = '0;
        m_ptr  = '0;
        m_full = 1'b0;
        m_st   = 0;
    endtask

    // One clock: drive inputs at negedge, push model expectation, compare after posedge.
    task automatic step(input string tag, input logic sclr, input logic mode,
                        input logic [3:0] ld_en, input logic [31:0] par,
                        input logic start, input logic valid, input logic [7:0] data);
        exp_t e;
        exp_t g;
        @(negedge clk);
        bus.sclr      = sclr;
        bus.mode      = mode;
        bus.ld_en     = ld_en;
        bus.par_in    = par;
        bus.seq_start = start;
        bus.seq_valid = valid;
        bus.seq_data  = data;
        if (sclr) begin
            model_reset();
        end else if (!mode) begin
            m_st  = 0;
            m_ptr = '0;
            for (int i = 0; i < 4; i++)
                if (ld_en[i]) m_out[i*8 +: 8] = par[i*8 +: 8];
        end else if (start) begin
            m_st   = 1;
            m_ptr  = '0;
            m_full = 1'b0;
        end else if (m_st == 1 && valid) begin
            m_out[m_ptr*8 +: 8] = data;
            if (m_ptr == 2'd3) begin
                m_st   = 2;
                m_full = 1'b1;
                m_ptr  = '0;
            end else begin
                m_ptr = m_ptr + 2'd1;
            end
        end
        e.tag  = tag;
        e.out  = m_out;
        e.ptr  = m_ptr;
        e.full = m_full;
        e.rdy  = (m_st == 1);
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        g = q_exp.pop_front();
        chk({g.tag, ".out"},  bus.out, g.out);
        chk({g.tag, ".ptr"},  32'(bus.fill_ptr), 32'(g.ptr));
        chk({g.tag, ".full"}, 32'(bus.full), 32'(g.full));
        chk({g.tag, ".rdy"},  32'(bus.seq_ready), 32'(g.rdy));
        chk({g.tag, ".busy"}, 32'(bus.busy), 32'(g.rdy));
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        bus.sclr      = 1'b0;
        bus.mode      = 1'b0;
        bus.ld_en     = '0;
        bus.par_in    = '0;
        bus.seq_start = 1'b0;
        bus.seq_valid = 1'b0;
        bus.seq_data  = '0;
        model_reset();
        clear_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out", bus.out, 32'h0);
        chk("rst.rdy", 32'(bus.seq_ready), 32'h0);
        @(negedge clk);
        clear_n = 1'b1;

        // Async reset mid-fill: out=12345678, ptr=2.
        step("t1.pl",  0, 0, 4'hF, 32'h12345678, 0, 0, 8'h00);
        step("t1.st",  0, 1, 4'h0, 32'h0, 1, 0, 8'h00);
        step("t1.b0",  0, 1, 4'h0, 32'h0, 0, 1, 8'h78);
        step("t1.b1",  0, 1, 4'h0, 32'h0, 0, 1, 8'h56);
        chk("t1.pre.out", bus.out, 32'h12345678);
        chk("t1.pre.ptr", 32'(bus.fill_ptr), 32'd2);
        #2;
        clear_n = 1'b0;
        #1;
        chk("t1.async.out",  bus.out, 32'h0);
        chk("t1.async.ptr",  32'(bus.fill_ptr), 32'd0);
        chk("t1.async.full", 32'(bus.full), 32'd0);
        chk("t1.async.rdy",  32'(bus.seq_ready), 32'd0);
        model_reset();
        @(negedge clk);
        clear_n = 1'b1;
        bus.mode = 1'b0;

        // Parallel load then hold.
        step("t2.ld",   0, 0, 4'b0101, 32'hAABBCCDD, 0, 0, 8'h00);
        chk("t2.val", bus.out, 32'h00BB00DD);
        step("t2.hold", 0, 0, 4'b0000, 32'h01020304, 0, 0, 8'h00);
        chk("t2.holdval", bus.out, 32'h00BB00DD);

        // Sequential fill with a 2-cycle gap after 22; ld_en ignored in mode 1.
        step("t3.st",  0, 1, 4'hF, 32'hDEADBEEF, 1, 0, 8'h00);
        step("t3.b0",  0, 1, 4'hF, 32'hDEADBEEF, 0, 1, 8'h11);
        step("t3.b1",  0, 1, 4'h0, 32'h0, 0, 1, 8'h22);
        step("t3.g0",  0, 1, 4'h0, 32'h0, 0, 0, 8'h77);
        chk("t3.gap.ptr", 32'(bus.fill_ptr), 32'd2);
        step("t3.g1",  0, 1, 4'h0, 32'h0, 0, 0, 8'h77);
        step("t3.b2",  0, 1, 4'h0, 32'h0, 0, 1, 8'h33);
        step("t3.b3",  0, 1, 4'h0, 32'h0, 0, 1, 8'h44);
        chk("t3.out",  bus.out, 32'h44332211);
        chk("t3.full", 32'(bus.full), 32'd1);
        chk("t3.rdy",  32'(bus.seq_ready), 32'd0);
        step("t3.done", 0, 1, 4'h0, 32'h0, 0, 1, 8'h55);
        chk("t3.doneval", bus.out, 32'h44332211);

        // Restart with a simultaneous beat: FF dropped.
        step("t4.st",  0, 1, 4'h0, 32'h0, 1, 0, 8'h00);
        step("t4.b0",  0, 1, 4'h0, 32'h0, 0, 1, 8'hA1);
        step("t4.b1",  0, 1, 4'h0, 32'h0, 0, 1, 8'hA2);
        step("t4.rs",  0, 1, 4'h0, 32'h0, 1, 1, 8'hFF);
        chk("t4.lo",  32'(bus.out[15:0]), 32'h0000A2A1);
        chk("t4.ptr", 32'(bus.fill_ptr), 32'd0);
        chk("t4.full", 32'(bus.full), 32'd0);

        // Abort mid-fill by switching to parallel mode.
        step("t5.b0",  0, 1, 4'h0, 32'h0, 0, 1, 8'hC0);
        step("t5.ab",  0, 0, 4'b1000, 32'h99000000, 0, 1, 8'hEE);
        chk("t5.lane3", 32'(bus.out[31:24]), 32'h99);
        chk("t5.lane0", 32'(bus.out[7:0]), 32'hC0);
        chk("t5.ptr",   32'(bus.fill_ptr), 32'd0);

        // Full survives a mode change; sync clear wipes everything mid-fill.
        step("t6.st",  0, 1, 4'h0, 32'h0, 1, 0, 8'h00);
        for (int i = 0; i < 4; i++)
            step("t6.fill", 0, 1, 4'h0, 32'h0, 0, 1, 8'(8'h60 + i));
        step("t6.m0",  0, 0, 4'h0, 32'h0, 0, 0, 8'h00);
        chk("t6.fullkeep", 32'(bus.full), 32'd1);
        step("t6.st2", 0, 1, 4'h0, 32'h0, 1, 0, 8'h00);
        step("t6.b0",  0, 1, 4'h0, 32'h0, 0, 1, 8'h5A);
        step("t6.clr", 1, 1, 4'hF, 32'hFFFFFFFF, 0, 1, 8'hA5);
        chk("t6.out", bus.out, 32'h0);
        chk("t6.rdy", 32'(bus.seq_ready), 32'd0);

        // Randomised tail against the model.
        for (int i = 0; i < 60; i++)
            step("rnd", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 4'($urandom), $urandom, ($urandom_range(0, 7) == 0),
                 1'($urandom), 8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
